// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [2:0] LAST_CODE        = 3'd7;
    localparam int         DEF_BLANK_CYCLES = 2;
    localparam int         DEF_DWELL_W      = 8;

endpackage

// File: rtl/decoder_scan_sequencer_timer.sv
// Loadable down-counter; holds at zero until the next load.
module scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps decoder select lines through codes 0..7 with a blanked Enable
// between codes and a programmable Enable-high dwell at each code.
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int NUM_CODES    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               Enable,
    output logic               busy,
    output logic               frame_done,
    output logic [2:0]         code
);

    localparam bit              HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam int              BLANK_M1_I = HAS_BLANK ? BLANK_CYCLES - 1 : 0;
    localparam logic [DWELL_W-1:0] BLANK_M1 = DWELL_W'(BLANK_M1_I);
    localparam logic [2:0]      FINAL_CODE = (NUM_CODES == 8) ? LAST_CODE : 3'(NUM_CODES - 1);

    scan_state_t        state;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_eff;
    logic               timer_zero;
    logic               timer_load;
    logic [DWELL_W-1:0] timer_value;
    logic               start_go;
    logic               blank_done;
    logic               drive_done;
    logic               last_code;
    logic               restart;

    assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign last_code  = (code == FINAL_CODE);
    assign start_go   = (state == IDLE)  && start && !stop;
    assign blank_done = (state == BLANK) && timer_zero && !stop;
    assign drive_done = (state == DRIVE) && timer_zero && !stop;
    assign restart    = drive_done && last_code && continuous;

    // Timer is reloaded on every state entry; frame (re)starts use the fresh dwell.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (start_go || restart) begin
            timer_load  = 1'b1;
            timer_value = HAS_BLANK ? BLANK_M1 : dwell_eff - 1'b1;
        end else if (blank_done) begin
            timer_load  = 1'b1;
            timer_value = dwell_lat - 1'b1;
        end else if (drive_done && !last_code) begin
            timer_load  = 1'b1;
            timer_value = HAS_BLANK ? BLANK_M1 : dwell_lat - 1'b1;
        end
    end

    scan_timer #(
        .WIDTH(DWELL_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(timer_value),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code       <= '0;
            Enable     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dwell_lat  <= DWELL_W'(1);
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && stop) begin
                state  <= IDLE;
                code   <= '0;
                Enable <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        Enable <= 1'b0;
                        code   <= '0;
                        if (start_go) begin
                            dwell_lat <= dwell_eff;
                            busy      <= 1'b1;
                            state     <= HAS_BLANK ? BLANK : DRIVE;
                            Enable    <= !HAS_BLANK;
                        end
                    end
                    BLANK: begin
                        if (timer_zero) begin
                            state  <= DRIVE;
                            Enable <= 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (timer_zero) begin
                            if (!last_code) begin
                                code   <= code + 3'd1;
                                state  <= HAS_BLANK ? BLANK : DRIVE;
                                Enable <= !HAS_BLANK;
                            end else begin
                                frame_done <= 1'b1;
                                code       <= '0;
                                if (continuous) begin
                                    dwell_lat <= dwell_eff;
                                    state     <= HAS_BLANK ? BLANK : DRIVE;
                                    Enable    <= !HAS_BLANK;
                                end else begin
                                    state  <= IDLE;
                                    Enable <= 1'b0;
                                    busy   <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        code   <= '0;
                        Enable <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign A = code[2];
    assign B = code[1];
    assign C = code[0];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer with a 3-to-8 decoder model on its outputs.
module tb_decoder_scan_sequencer;

    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [7:0] dwell;
    logic       A, B, C, Enable, busy, frame_done;
    logic [2:0] code;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] prev_code = '0;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(
        .DWELL_W     (8),
        .BLANK_CYCLES(BLANK),
        .NUM_CODES   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .continuous(continuous),
        .dwell     (dwell),
        .A         (A),
        .B         (B),
        .C         (C),
        .Enable    (Enable),
        .busy      (busy),
        .frame_done(frame_done),
        .code      (code)
    );

    function automatic logic [7:0] dec3to8(input logic en, input logic a, input logic b, input logic c);
        logic [2:0] sel;
        sel = {a, b, c};
        return en ? (8'b1 << sel) : 8'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] c, input logic en,
                              input logic bz, input logic fd);
        check_eq({tag, "_code"}, 32'(code), 32'(c));
        check_eq({tag, "_abc"}, 32'({A, B, C}), 32'(c));
        check_eq({tag, "_en"}, 32'(Enable), 32'(en));
        check_eq({tag, "_busy"}, 32'(busy), 32'(bz));
        check_eq({tag, "_fd"}, 32'(frame_done), 32'(fd));
    endtask

    // Walks one whole frame from the cycle after its start edge; optionally
    // changes dwell/continuous at cycle chg_k.
    task automatic run_frame(input string tag, input int d, input bit restarted,
                             input int chg_k, input logic [7:0] nd, input logic nc);
        int per;
        per = BLANK + d;
        for (int k = 0; k < 8 * per; k++) begin
            if (k == chg_k) begin
                dwell      = nd;
                continuous = nc;
            end
            expect_out($sformatf("%s_k%0d", tag, k), 3'(k / per), (k % per) >= BLANK,
                       1'b1, restarted && (k == 0));
            step();
        end
    endtask

    // Decoder-side invariants, sampled every cycle.
    always @(posedge clk) begin
        #2;
        check_eq("en_on_code_change", 32'(Enable && (code != prev_code)), 32'd0);
        check_eq("decode_onehot", 32'(dec3to8(Enable, A, B, C)),
                 32'(Enable ? (8'b1 << code) : 8'b0));
        prev_code = code;
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        dwell      = 8'd3;
        step();
        step();
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        expect_out("idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Single frame, dwell 3: 40 cycles then one frame_done.
        dwell = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("single", 3, 1'b0, -1, 8'd0, 1'b0);
        expect_out("single_end", 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("single_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // Continuous, dwell 1; continuous dropped mid second frame.
        dwell      = 8'd1;
        continuous = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        run_frame("cont1", 1, 1'b0, -1, 8'd1, 1'b1);
        run_frame("cont2", 1, 1'b1, 10, 8'd1, 1'b0);
        expect_out("cont_end", 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("cont_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // dwell 0 behaves as dwell 1.
        dwell = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("dw0", 1, 1'b0, -1, 8'd0, 1'b0);
        expect_out("dw0_end", 3'd0, 1'b0, 1'b0, 1'b1);
        step();

        // Mid-frame dwell change only takes effect at the restart.
        dwell      = 8'd2;
        continuous = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        run_frame("dwchg1", 2, 1'b0, 5, 8'd4, 1'b1);
        run_frame("dwchg2", 4, 1'b1, 3, 8'd4, 1'b0);
        expect_out("dwchg_end", 3'd0, 1'b0, 1'b0, 1'b1);
        step();

        // stop during code 3 DRIVE.
        dwell = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 17; i++) step();
        expect_out("pre_stop", 3'd3, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("stopped", 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("stopped2", 3'd0, 1'b0, 1'b0, 1'b0);

        // stop and start together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        expect_out("stop_start", 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        step();
        expect_out("stop_start2", 3'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during code 5 DRIVE.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 27; i++) step();
        expect_out("pre_reset", 3'd5, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        expect_out("post_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. It steps the select lines A/B/C through codes 0..7 and holds Enable high for a programmable dwell time at each code. Enable is forced low for a fixed blanking interval whenever the code changes, so no two decoder outputs ever glitch active together. Typical use is column/row scan of LED or display matrices, in single-frame or free-running mode.

Parameters:
DWELL_W, 8, width of the dwell-count input and the internal timer
BLANK_CYCLES, 2, Enable-low cycles before each code is driven (0 is legal and means no blanking)
NUM_CODES, 8, codes per frame; fixed at 8 to match the 3-bit select

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse or level; begins a frame when sampled in IDLE
stop  input  1  synchronous abort; returns the block to IDLE
continuous  input  1  sampled at frame end; 1 = restart at code 0, 0 = go to IDLE
dwell  input  DWELL_W  Enable-high cycles per code; latched at frame start; 0 is treated as 1
A  output  1  select MSB (code bit 2), registered
B  output  1  select bit 1, registered
C  output  1  select LSB (code bit 0), registered
Enable  output  1  decoder enable, registered
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after code 7 finishes its dwell
code  output  3  current code {A,B,C}, exposed for debug

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; A=B=C=0, Enable=0, busy=0, frame_done=0, code=0, timer=0, dwell_lat=1.
- All outputs are registered and change only on rising clk edges.
- States:
  - IDLE: Enable=0, code=0. On start=1 and stop=0: latch dwell_eff = max(dwell,1), set code=0. Go to BLANK if BLANK_CYCLES>0, else to DRIVE. Any other cycle: stay.
  - BLANK: Enable=0, code held. Stay exactly BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: Enable=1, code held. Stay exactly dwell_eff cycles. Then:
    - If code<7: code+1, go to BLANK (or to DRIVE if BLANK_CYCLES=0).
    - If code==7: assert frame_done in the next cycle. If continuous=1: code=0, re-latch dwell, go to BLANK/DRIVE. Else go to IDLE.
- Latency:
  - With start sampled at edge N, busy=1 and code=0 from edge N.
  - Enable first rises at edge N+BLANK_CYCLES.
  - Frame length is exactly 8*(BLANK_CYCLES+dwell_eff) cycles.
  - Continuous frames are back-to-back with no idle gap.
- Code sequence is 0,1,...,7 and then wraps to 0 only in continuous mode. No code is ever skipped.
- Timer: one DWELL_W-bit down-counter, reloaded on every state entry. The width must also hold BLANK_CYCLES.
- stop=1 in any non-IDLE state: the next edge forces IDLE with Enable=0, code=0, busy=0, and no frame_done.
- stop=1 together with start=1 in IDLE: stop wins and the block stays IDLE.
- start while busy is ignored; it is not queued.
- A dwell change mid-frame has no effect until the next frame start or restart.
- Reset asserted mid-frame: all outputs go to their reset values immediately, with no clock needed.
- Enable is never high in the cycle in which code changes.

Decomposition:
- Package decoder_scan_pkg holds:
  - the state enum (IDLE, BLANK, DRIVE), 2-bit encoding;
  - the constant LAST_CODE = 3'd7;
  - the defaults for BLANK_CYCLES and DWELL_W.
- One natural sub-module, scan_timer: a loadable down-counter with a load value, a load strobe, and a zero flag.
- The FSM, code register and output registers stay in the top level.

Test Plan:
- Reset: rst_n=0 mid-DRIVE with code=5 -> A,B,C,Enable,busy all 0 immediately; IDLE after release.
- Single frame: BLANK_CYCLES=2, dwell=3, continuous=0, start pulse -> codes 0..7 each with 2 cycles Enable=0 then 3 cycles Enable=1; frame_done pulses once at cycle 40; busy=0 afterwards.
- Continuous: dwell=1, continuous=1 -> after code 7 the block returns to code 0 with no gap and frame_done pulses every 24 cycles. Dropping continuous before the second frame end -> IDLE after the second frame.
- dwell=0 -> behaves exactly as dwell=1. A dwell change mid-frame is applied only from the next frame.
- stop at code 3 in DRIVE -> next edge Enable=0, busy=0, code=0, no frame_done. stop+start in the same cycle in IDLE -> remains IDLE.
- Checker, run every cycle through the DUT connected to the 3-to-8 decoder: Decode_Out is one-hot with the bit at index code when Enable=1, and all zero otherwise. Enable is never 1 in a cycle where code differs from the previous cycle.
